// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit path.
//   - State encodings for the serializer FSM (IDLE, START, DATA, PARITY, STOP)
//   - frame_bits(): number of bit periods in one frame for a given config
//   - FRAME_BITS: frame length, in bit periods, for the default configuration
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_e;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_PARITY_EN = 0;
    localparam int DEF_STOP_BITS = 1;

    // Start bit + data bits + optional parity + stop bits.
    function automatic int frame_bits(input int data_size,
                                      input int parity_en,
                                      input int stop_bits);
        return 1 + data_size + parity_en + stop_bits;
    endfunction

    localparam int FRAME_BITS = frame_bits(DEF_DATA_SIZE, DEF_PARITY_EN, DEF_STOP_BITS);

endpackage

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter
// Bit-period timer for the UART transmitter. The divisor is latched on
// load_i so that divisor changes only take effect at the next frame start.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   load_i  - restart the count at 0 and latch div_i
//   div_i   - bit period minus one, in clocks
//   tick_o  - high in the last cycle of every bit period
// ---------------------------------------------------------------------------
module uart_baud_counter
    import uart_tx_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;

    assign tick_o = (cnt_q == div_q);

    // The counter wraps at the latched divisor, so every bit lasts div_q+1
    // clocks; a load restarts the first bit of a new frame cleanly.
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (load_i) begin
            cnt_d = '0;
            div_d = div_i;
        end else if (cnt_q == div_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// Reader side of the TX FIFO: pops one character when data is available and
// the transmitter is enabled, and shifts it out as
//   start(0), DATA_SIZE data bits LSB-first, optional parity, STOP_BITS stop(1).
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous active-high reset
//   tx_en_i      - allows new frames to start
//   baud_div_i   - bit period = baud_div_i+1 clocks (latched per frame)
//   fifo_load_i  - FIFO head holds valid data
//   fifo_data_i  - FIFO head data
//   fifo_pull_o  - one-cycle pop strobe to the FIFO
//   uart_tx_o    - serial line, idle high, registered
//   busy_o       - a frame is in progress
//   done_o       - one-cycle pulse right after the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tx_en_i,
    input  logic [DIV_WIDTH-1:0] baud_div_i,
    input  logic                 fifo_load_i,
    input  logic [DATA_SIZE-1:0] fifo_data_i,
    output logic                 fifo_pull_o,
    output logic                 uart_tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int                IDX_W     = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_SIZE - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [DATA_SIZE-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;

    logic                   tick_w;
    logic                   last_stop_w;
    logic                   take_w;

    uart_baud_counter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (take_w),
        .div_i  (baud_div_i),
        .tick_o (tick_w)
    );

    // A new character may be taken when idle, or in the final cycle of the
    // last stop bit so that back-to-back frames have no idle gap. Reset
    // masks the pop so no character is lost while the FSM is being cleared.
    assign last_stop_w = (state_q == STOP) && tick_w && (stop_idx_q == LAST_STOP);
    assign take_w      = !rst_i && tx_en_i && fifo_load_i &&
                         ((state_q == IDLE) || last_stop_w);

    assign fifo_pull_o = take_w;
    assign uart_tx_o   = tx_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

    // Next-state logic. The line value is computed one cycle ahead so that
    // uart_tx_o comes straight from a flop and changes exactly on the bit
    // boundary. The shift register is shifted as each bit is handed to the
    // line, so bit 0 of shift_q is always the next data bit to send.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (take_w) begin
                    state_d  = START;
                    shift_d  = fifo_data_i;
                    parity_d = (^fifo_data_i) ^ (PARITY_ODD != 0);
                    tx_d     = 1'b0;
                end
            end

            START: begin
                if (tick_w) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end

            DATA: begin
                if (tick_w) begin
                    if (bit_idx_q == LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end

            PARITY: begin
                if (tick_w) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end

            STOP: begin
                if (tick_w) begin
                    if (stop_idx_q == LAST_STOP) begin
                        done_d = 1'b1;
                        if (take_w) begin
                            state_d  = START;
                            shift_d  = fifo_data_i;
                            parity_d = (^fifo_data_i) ^ (PARITY_ODD != 0);
                            tx_d     = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // All state and registered outputs; reset aborts any frame in progress
    // without a done pulse and returns the line to idle-high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

endmodule
